// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path definitions: header/FCS lengths, broadcast
// address and the parser FSM state encoding.
package eth_pkg;

  localparam int          ETH_HDR_LEN   = 14;
  localparam int          ETH_FCS_LEN   = 4;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } eth_state_e;

endpackage

// File: rtl/rx_fcs_strip.sv
// Trailing-FCS remover: holds the most recent ETH_FCS_LEN bytes so the
// frame tail never reaches the output, and drives a registered AXIS stage.
module rx_fcs_strip
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_user,
  output logic       buf_full,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       m_axis_tready
);

  localparam logic [2:0] FILL_MAX = 3'(ETH_FCS_LEN);

  // dly[0] is the newest byte, dly[ETH_FCS_LEN-1] the oldest
  logic [7:0] dly [ETH_FCS_LEN];
  logic [2:0] fill;

  assign buf_full = (fill == FILL_MAX);

  // Delay line shift and fill tracking; a last beat always empties the line
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill <= '0;
      for (int i = 0; i < ETH_FCS_LEN; i++) dly[i] <= '0;
    end else if (s_valid) begin
      dly[0] <= s_data;
      for (int i = 1; i < ETH_FCS_LEN; i++) dly[i] <= dly[i-1];
      if (s_last)
        fill <= '0;
      else if (!buf_full)
        fill <= fill + 3'd1;
    end
  end

  // Output register: loaded with the displaced oldest byte once the line is full.
  // The caller only presents s_valid with a full line when this slot is free.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (s_valid && buf_full) begin
        m_axis_tdata  <= dly[ETH_FCS_LEN-1];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= s_last;
        m_axis_tuser  <= s_last && s_user;
      end
    end
  end

endmodule

// File: rtl/rx_eth_hdr_parser.sv
// Ethernet receive header parser: captures DA/SA/EtherType, filters on the
// destination address, strips header and FCS, and keeps frame statistics.
module rx_eth_hdr_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
  parameter bit          PROMISC   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [47:0] m_hdr_dst_mac,
  output logic [47:0] m_hdr_src_mac,
  output logic [15:0] m_hdr_ethertype,
  output logic        m_hdr_valid,
  output logic [15:0] stat_drop_cnt,
  output logic [15:0] stat_err_cnt,
  output logic [15:0] stat_runt_cnt
);

  localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

  eth_state_e  state, state_nxt;
  logic [3:0]  hdr_cnt;
  logic        run;
  logic [47:0] dst_sh, src_sh;
  logic [7:0]  type_hi;
  logic        s_fire;
  logic        hdr_last_byte;
  logic        hdr_pass;
  logic        buf_full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign hdr_last_byte = (hdr_cnt == HDR_LAST);
  assign hdr_pass      = PROMISC || (dst_sh == LOCAL_MAC) || (dst_sh == ETH_BCAST_MAC);

  // State register; run holds the input port closed for the cycle after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_HDR;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Next-state: header completion decides PAYLOAD/DROP, any last beat returns to HDR
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR: begin
        if (s_fire && !s_axis_tlast && hdr_last_byte)
          state_nxt = hdr_pass ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD, ST_DROP: begin
        if (s_fire && s_axis_tlast)
          state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // Input backpressure: only the payload path can stall, when the delay line
  // is full and the output register is still holding an unaccepted beat
  always_comb begin
    s_axis_tready = 1'b0;
    if (run) begin
      case (state)
        ST_PAYLOAD: s_axis_tready = !buf_full || !m_axis_tvalid || m_axis_tready;
        default:    s_axis_tready = 1'b1;
      endcase
    end
  end

  // Header byte counter and shadow capture of DA, SA and EtherType high byte
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hdr_cnt <= '0;
      dst_sh  <= '0;
      src_sh  <= '0;
      type_hi <= '0;
    end else if (state == ST_HDR && s_fire) begin
      if (s_axis_tlast || hdr_last_byte)
        hdr_cnt <= '0;
      else
        hdr_cnt <= hdr_cnt + 4'd1;
      if (hdr_cnt < 4'd6)
        dst_sh <= {dst_sh[39:0], s_axis_tdata};
      else if (hdr_cnt < 4'd12)
        src_sh <= {src_sh[39:0], s_axis_tdata};
      else if (hdr_cnt == 4'd12)
        type_hi <= s_axis_tdata;
    end
  end

  // Published header fields: updated only when a complete header passes the filter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_hdr_dst_mac   <= '0;
      m_hdr_src_mac   <= '0;
      m_hdr_ethertype <= '0;
      m_hdr_valid     <= 1'b0;
    end else begin
      m_hdr_valid <= 1'b0;
      if (state == ST_HDR && s_fire && !s_axis_tlast && hdr_last_byte && hdr_pass) begin
        m_hdr_dst_mac   <= dst_sh;
        m_hdr_src_mac   <= src_sh;
        m_hdr_ethertype <= {type_hi, s_axis_tdata};
        m_hdr_valid     <= 1'b1;
      end
    end
  end

  // Frame statistics, each saturating
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_drop_cnt <= '0;
      stat_err_cnt  <= '0;
      stat_runt_cnt <= '0;
    end else if (s_fire) begin
      case (state)
        ST_HDR: begin
          if (s_axis_tlast)
            stat_runt_cnt <= sat_inc(stat_runt_cnt);
          else if (hdr_last_byte && !hdr_pass)
            stat_drop_cnt <= sat_inc(stat_drop_cnt);
        end
        ST_PAYLOAD: begin
          if (s_axis_tlast && !buf_full)
            stat_runt_cnt <= sat_inc(stat_runt_cnt);
          if (s_axis_tlast && s_axis_tuser)
            stat_err_cnt <= sat_inc(stat_err_cnt);
        end
        default: ;
      endcase
    end
  end

  rx_fcs_strip u_fcs_strip (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_data        (s_axis_tdata),
    .s_valid       (s_fire && (state == ST_PAYLOAD)),
    .s_last        (s_axis_tlast),
    .s_user        (s_axis_tuser),
    .buf_full      (buf_full),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_rx_eth_hdr_parser.sv
// Scoreboard bench for rx_eth_hdr_parser: a frame-level model predicts payload
// beats, header captures and statistics; monitors compare as the DUT emits.
module tb_rx_eth_hdr_parser;

  localparam logic [47:0] LOCAL = 48'h000A35000001;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_et;
  logic        hdr_valid;
  logic [15:0] drop_cnt, err_cnt, runt_cnt;

  always #5 clk = ~clk;

  rx_eth_hdr_parser #(.LOCAL_MAC(LOCAL), .PROMISC(1'b0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .s_axis_tready   (s_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .m_axis_tready   (m_tready),
    .m_hdr_dst_mac   (hdr_dst),
    .m_hdr_src_mac   (hdr_src),
    .m_hdr_ethertype (hdr_et),
    .m_hdr_valid     (hdr_valid),
    .stat_drop_cnt   (drop_cnt),
    .stat_err_cnt    (err_cnt),
    .stat_runt_cnt   (runt_cnt)
  );

  typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;
  typedef struct packed { logic [47:0] dst; logic [47:0] src; logic [15:0] et; } hdr_t;

  beat_t      exp_q[$];
  hdr_t       hdr_q[$];
  logic [7:0] frm[$];
  int         exp_drop, exp_err, exp_runt;
  int         errors = 0;
  int         checks = 0;
  bit         bypass = 1'b1;
  bit         chk_rdy = 1'b0;
  int         rdy_mode = 0;
  beat_t      eb;
  hdr_t       eh;
  bit         stall_prev = 1'b0;
  logic [9:0] stall_val;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame-level reference: classify by length and DA, then list expected beats
  task automatic model_frame(input bit tu);
    int n;
    logic [47:0] dst, src;
    n = frm.size();
    if (n <= 14) begin exp_runt++; return; end
    for (int i = 0; i < 6; i++) begin
      dst = {dst[39:0], frm[i]};
      src = {src[39:0], frm[i+6]};
    end
    if (dst != LOCAL && dst != BCAST) begin exp_drop++; return; end
    eh.dst = dst; eh.src = src; eh.et = {frm[12], frm[13]};
    hdr_q.push_back(eh);
    if (tu) exp_err++;
    if (n - 14 < 5) begin exp_runt++; return; end
    for (int i = 14; i <= n - 5; i++) begin
      eb.d = frm[i]; eb.l = (i == n - 5); eb.u = (i == n - 5) && tu;
      exp_q.push_back(eb);
    end
  endtask

  task automatic make_frame(input logic [47:0] dst, input logic [15:0] et,
                            input int nbytes, input bit seq);
    logic [47:0] src;
    src = {16'h0A0B, 32'($urandom)};
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < nbytes - 14; i++)
      frm.push_back((seq && i < nbytes - 18) ? 8'(i) : 8'($urandom));
    while (frm.size() > nbytes) void'(frm.pop_back());
  endtask

  task automatic send_frame(input bit tu, input int gap_pct, input int upto);
    int n, wd;
    bit acc;
    n = frm.size();
    for (int i = 0; i < upto; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tdata  = frm[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      s_tuser  = (i == n - 1) ? tu : 1'($urandom_range(0, 1));
      acc = 1'b0;
      wd  = 0;
      while (!acc && wd < 2000) begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk); #1;
        wd++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL s_handshake actual=timeout required=accept byte %0d", i);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain();
    int wd = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0) && wd < 3000) begin
      @(posedge clk); wd++;
    end
    chk("drain_pending", 128'(exp_q.size() + hdr_q.size()), 128'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_drop"}, 128'(drop_cnt), 128'(exp_drop));
    chk({tag, "_err"},  128'(err_cnt),  128'(exp_err));
    chk({tag, "_runt"}, 128'(runt_cnt), 128'(exp_runt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_tvalid"}, 128'(m_tvalid), 128'd0);
    chk({tag, "_m_tlast"},  128'(m_tlast),  128'd0);
    chk({tag, "_m_tuser"},  128'(m_tuser),  128'd0);
    chk({tag, "_m_tdata"},  128'(m_tdata),  128'd0);
    chk({tag, "_hdr_valid"}, 128'(hdr_valid), 128'd0);
    chk({tag, "_hdr_dst"},  128'(hdr_dst),  128'd0);
    chk({tag, "_hdr_src"},  128'(hdr_src),  128'd0);
    chk({tag, "_hdr_et"},   128'(hdr_et),   128'd0);
    chk({tag, "_s_tready"}, 128'(s_tready), 128'd0);
    chk({tag, "_drop"},     128'(drop_cnt), 128'd0);
    chk({tag, "_err"},      128'(err_cnt),  128'd0);
    chk({tag, "_runt"},     128'(runt_cnt), 128'd0);
  endtask

  // Downstream ready pattern: always ready, alternating, or random
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations on every output handshake and header pulse
  always @(negedge clk) begin
    if (!bypass) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_beat actual=%0h/%0b/%0b required=no beat", m_tdata, m_tlast, m_tuser);
        end else begin
          eb = exp_q.pop_front();
          chk("out_beat", 128'({m_tdata, m_tlast, m_tuser}), 128'({eb.d, eb.l, eb.u}));
        end
      end
      if (hdr_valid) begin
        if (hdr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr_pulse actual=pulse required=none");
        end else begin
          eh = hdr_q.pop_front();
          chk("hdr_fields", {16'd0, hdr_dst, hdr_src, hdr_et}, {16'd0, eh.dst, eh.src, eh.et});
        end
      end
      if (chk_rdy && !s_tready)
        chk("s_tready_only_on_stall", 128'({m_tvalid, m_tready}), 128'(2'b10));
      if (stall_prev && m_tvalid)
        chk("out_hold_on_stall", 128'({m_tdata, m_tlast, m_tuser}), 128'(stall_val));
      stall_prev = m_tvalid && !m_tready;
      stall_val  = {m_tdata, m_tlast, m_tuser};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    reset_n  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    exp_drop = 0; exp_err = 0; exp_runt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    bypass  = 1'b0;
    chk_rdy = 1'b1;

    // Directed: unicast 64-byte frame with sequential payload
    make_frame(LOCAL, 16'h0800, 64, 1'b1);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    drain();
    chk("et_after_ipv4", 128'(hdr_et), 128'(16'h0800));
    check_stats("unicast");

    // Directed: foreign DA dropped, then a local frame passes
    make_frame(48'h112233445566, 16'h0800, 60, 1'b1);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    make_frame(LOCAL, 16'h86DD, 70, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 20, frm.size());
    drain();
    check_stats("drop");

    // Directed: broadcast frame flagged bad on its last beat
    make_frame(BCAST, 16'h0806, 64, 1'b1);
    model_frame(1'b1);
    send_frame(1'b1, 0, frm.size());
    drain();
    check_stats("bcast_err");

    // Directed: runt in header, runt just past the header
    make_frame(LOCAL, 16'h0800, 10, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    make_frame(LOCAL, 16'h0800, 17, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    drain();
    check_stats("runt");

    // Directed: alternating downstream ready, back-to-back frames
    rdy_mode = 1;
    make_frame(LOCAL, 16'h0800, 80, 1'b1);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    make_frame(BCAST, 16'h1234, 40, 1'b0);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    drain();
    check_stats("toggle");

    // Random frames: mixed lengths, addresses, bad flags, gaps and backpressure
    for (int f = 0; f < 40; f++) begin
      logic [47:0] d;
      int sel;
      bit tu;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = LOCAL;
        1:       d = BCAST;
        2:       d = {16'h0200, 32'($urandom)};
        default: d = LOCAL ^ (48'd1 << $urandom_range(0, 47));
      endcase
      tu = ($urandom_range(0, 3) == 0);
      rdy_mode = $urandom_range(0, 2);
      make_frame(d, 16'($urandom), $urandom_range(8, 72), 1'b0);
      model_frame(tu);
      send_frame(tu, $urandom_range(0, 40), frm.size());
    end
    drain();
    check_stats("random");

    // Reset at payload byte 20, then a clean frame
    rdy_mode = 0;
    bypass   = 1'b1;
    chk_rdy  = 1'b0;
    make_frame(LOCAL, 16'h0800, 64, 1'b1);
    send_frame(1'b0, 0, 35);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all_zero("midreset");
    exp_q.delete();
    hdr_q.delete();
    exp_drop = 0; exp_err = 0; exp_runt = 0;
    @(posedge clk); #1;
    bypass  = 1'b0;
    chk_rdy = 1'b1;
    make_frame(LOCAL, 16'h0800, 64, 1'b1);
    model_frame(1'b0);
    send_frame(1'b0, 0, frm.size());
    drain();
    check_stats("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_eth_hdr_parser.md
RX_ETH_HDR_PARSER -- requirements
Module: rx_eth_hdr_parser

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h000A35000001, the station MAC address accepted by the filter.
REQ-002 SHALL have parameter PROMISC, default 0; 1 disables destination filtering.
REQ-003 SHALL have port clk, input, 1: clock; reset reset_n, synchronous, active-low.
REQ-004 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata/tvalid/tlast/tuser, inputs, 8/1/1/1: frame stream from the receive MAC, DA through FCS inclusive, tuser=bad frame, qualified on tlast.
REQ-006 SHALL have port s_axis_tready, output, 1: accepts the input beat.
REQ-007 SHALL have port m_axis_tdata/tvalid/tlast/tuser, outputs, 8/1/1/1: payload stream with header and FCS removed.
REQ-008 SHALL have port m_axis_tready, input, 1: downstream accepts the output beat.
REQ-009 SHALL have port m_hdr_dst_mac/m_hdr_src_mac/m_hdr_ethertype, outputs, 48/48/16: captured header fields.
REQ-010 SHALL have port m_hdr_valid, output, 1: one-cycle pulse when an accepted header completes.
REQ-011 SHALL have port stat_drop_cnt/stat_err_cnt/stat_runt_cnt, outputs, 16 each: frame statistics.

Function
REQ-012 Transfer SHALL occur only on tvalid&&tready, on both ports.
REQ-013 FSM states SHALL be HDR, PAYLOAD, DROP; HDR uses a 4-bit byte counter 0..13.
REQ-014 In HDR, s_axis_tready SHALL be 1; bytes 0-5 fill dst_mac MSB-first, 6-11 src_mac, 12-13 ethertype MSB-first.
REQ-015 On byte 13, the frame SHALL pass when PROMISC=1, dst==LOCAL_MAC, or dst==48'hFFFFFFFFFFFF; pass -> PAYLOAD with m_hdr_valid pulsed the next cycle; fail -> DROP with stat_drop_cnt+1.
REQ-016 Header field outputs SHALL update only on byte 13 of a passing frame and hold otherwise.
REQ-017 tlast on any HDR byte SHALL discard the frame, increment stat_runt_cnt, and leave the FSM in HDR with the counter cleared.
REQ-018 PAYLOAD SHALL use a 4-byte delay buffer; the first 4 payload bytes fill it with no output.
REQ-019 With buffer full, each accepted input byte SHALL shift in, and the oldest byte SHALL load the registered output stage.
REQ-020 In PAYLOAD, s_axis_tready SHALL equal (buffer not full) || !m_axis_tvalid || m_axis_tready.
REQ-021 Input tlast with buffer full SHALL emit the shifted-out byte with m_axis_tlast=1 and m_axis_tuser=s_axis_tuser, discard the 4 remaining bytes as FCS, clear the buffer, and return to HDR.
REQ-022 Input tlast with buffer not full (<5 bytes after header) SHALL produce no output, increment stat_runt_cnt, and return to HDR.
REQ-023 Input tlast with tuser=1 SHALL increment stat_err_cnt whenever the frame reached PAYLOAD; in HDR/DROP it increments only runt/drop.
REQ-024 DROP SHALL hold s_axis_tready=1, discard bytes, and return to HDR after the tlast beat.
REQ-025 m_axis output SHALL hold data/flags stable while tvalid&&!tready; latency input-to-output SHALL be 1 cycle after buffer fill.
REQ-026 All stat counters SHALL saturate at 16'hFFFF.
REQ-027 A new frame's header bytes SHALL be accepted while the previous frame's last output beat is still pending.

Reset
REQ-028 On reset_n=0 at a clk edge: state HDR, counters/buffer cleared, m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, m_hdr_valid=0, header fields 0, stats 0, s_axis_tready=0.
REQ-029 Reset mid-frame SHALL abandon the frame without emitting tlast; upstream SHALL restart on a frame boundary.

Structure
REQ-030 Package eth_pkg SHALL hold ETH_HDR_LEN=14, ETH_FCS_LEN=4, ETH_BCAST_MAC, and the FSM state enum.
REQ-031 The 4-byte delay buffer SHALL be sub-module rx_fcs_strip; parsing, filtering, and stats stay in the top level.

Verification
REQ-032 64-byte frame, DA=LOCAL_MAC, type 16'h0800, payload 0x00..0x2D, tuser=0 -> 46 output bytes 0x00..0x2D, tlast on 0x2D, tuser=0, ethertype=16'h0800, one m_hdr_valid pulse.
REQ-033 Frame with DA=48'h112233445566, PROMISC=0 -> no output, stat_drop_cnt=1, next frame to LOCAL_MAC passes intact.
REQ-034 Broadcast frame, last beat tuser=1 -> full payload output, final beat tlast=1 tuser=1, stat_err_cnt=1.
REQ-035 10-byte frame (tlast in header), then 17-byte frame -> no output, stat_runt_cnt=2.
REQ-036 Valid frame with m_axis_tready toggling 1/0 each cycle -> payload bytes complete, in order, no duplicates; s_axis_tready deasserts only when the buffer is full and output is stalled.
REQ-037 reset_n low for 1 cycle at payload byte 20 -> all outputs 0 next cycle; following clean frame parses correctly.
